// File: rtl/axis_block_sig_gen.sv
// Purpose: per-channel AXI-Stream stall detector feeding the deadlock monitor with blocked flags and event statistics.
// Latency: a flag rises on the edge that ends the THRESH-th consecutive stall cycle and falls on the edge after any non-stall cycle.
// Backpressure: passive observer; never drives TVALID/TREADY. Outputs are fully registered.
module axis_block_sig_gen #(
   parameter int NUM_CH = 5,
   parameter int THRESH = 16,
   parameter int CNT_W  = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              clear,
   input  logic [NUM_CH-1:0] tvalid,
   input  logic [NUM_CH-1:0] tready,
   output logic [NUM_CH-1:0] axis_block_sigs,
   output logic              any_block,
   output logic              first_blk_vld,
   output logic [4:0]        first_blk_id,
   output logic [CNT_W-1:0]  blk_event_cnt
);

   localparam int RUN_W = $clog2(THRESH + 1);

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_BLOCKED = 1'b1;

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(THRESH);
   // A stall seen while the counter sits here completes the THRESH-th stall cycle.
   localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(THRESH - 1);

   logic [NUM_CH-1:0] stall;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] state;
   logic [NUM_CH-1:0] state_nxt;
   logic [RUN_W-1:0]  run [NUM_CH];

   logic [5:0]        n_rise;
   logic [4:0]        rise_id;
   logic [CNT_W+5:0]  cnt_sum;
   logic [CNT_W-1:0]  cnt_nxt;

   assign stall = tvalid & ~tready;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         assign rise[g]      = stall[g] && (state[g] == ST_IDLE) && (run[g] == RUN_ARM);
         assign state_nxt[g] = !stall[g] ? ST_IDLE : (rise[g] ? ST_BLOCKED : state[g]);

         // Per-channel stall run counter (saturating) and IDLE/BLOCKED state.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               run[g]   <= '0;
               state[g] <= ST_IDLE;
            end else if (clear) begin
               run[g]   <= '0;
               state[g] <= ST_IDLE;
            end else begin
               state[g] <= state_nxt[g];
               if (!stall[g])
                  run[g] <= '0;
               else if (run[g] < RUN_MAX)
                  run[g] <= run[g] + RUN_W'(1);
            end
         end
      end
   endgenerate

   assign axis_block_sigs = state;

   // Count rising channels this cycle and pick the lowest-numbered one.
   always_comb begin
      n_rise  = '0;
      rise_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rise[i]) begin
            n_rise  = n_rise + 6'd1;
            rise_id = 5'(i);
         end
      end
   end

   // Saturating add of this cycle's rising edges onto the event counter.
   always_comb begin
      cnt_sum = {6'd0, blk_event_cnt} + {{CNT_W{1'b0}}, n_rise};
      cnt_nxt = (cnt_sum > {6'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   // Aggregate outputs: OR of next flags, event counter and sticky first-blocker record.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         any_block     <= 1'b0;
         first_blk_vld <= 1'b0;
         first_blk_id  <= '0;
         blk_event_cnt <= '0;
      end else if (clear) begin
         any_block     <= 1'b0;
         first_blk_vld <= 1'b0;
         first_blk_id  <= '0;
         blk_event_cnt <= '0;
      end else begin
         any_block     <= |state_nxt;
         blk_event_cnt <= cnt_nxt;
         if (!first_blk_vld && (|rise)) begin
            first_blk_vld <= 1'b1;
            first_blk_id  <= rise_id;
         end
      end
   end

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Purpose: self-checking bench for axis_block_sig_gen (THRESH=4 and THRESH=1 instances, CNT_W=2).
// Latency: reference model tracks stall streak lengths; outputs compared every cycle on the falling edge.
// Backpressure: stimulus drives tvalid/tready patterns directly; no handshake waits.
module tb_axis_block_sig_gen;

   localparam int NCH  = 5;
   localparam int CMAX = 3;

   logic       ap_clk = 1'b0;
   logic       ap_rst_n;
   logic       clear;
   logic [4:0] tvalid;
   logic [4:0] tready;

   logic [4:0] blk0, blk1;
   logic       any0, any1;
   logic       fv0, fv1;
   logic [4:0] fid0, fid1;
   logic [1:0] cnt0, cnt1;

   always #5 ap_clk = ~ap_clk;

   axis_block_sig_gen #(.NUM_CH(5), .THRESH(4), .CNT_W(2)) u_dut0 (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .clear           (clear),
      .tvalid          (tvalid),
      .tready          (tready),
      .axis_block_sigs (blk0),
      .any_block       (any0),
      .first_blk_vld   (fv0),
      .first_blk_id    (fid0),
      .blk_event_cnt   (cnt0)
   );

   axis_block_sig_gen #(.NUM_CH(5), .THRESH(1), .CNT_W(2)) u_dut1 (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .clear           (clear),
      .tvalid          (tvalid),
      .tready          (tready),
      .axis_block_sigs (blk1),
      .any_block       (any1),
      .first_blk_vld   (fv1),
      .first_blk_id    (fid1),
      .blk_event_cnt   (cnt1)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: length of the current unbroken stall streak per channel.
   int streak [2][NCH];
   int m_cnt  [2];
   int m_fv   [2];
   int m_fid  [2];
   int th     [2] = '{4, 1};
   int m_nr;
   int m_lo;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_flags(input int d);
      int f;
      f = 0;
      for (int ch = 0; ch < NCH; ch++)
         if (streak[d][ch] >= th[d]) f = f | (1 << ch);
      return f;
   endfunction

   // Model update: a channel blocks when its streak reaches THRESH; streak length is unbounded.
   always @(posedge ap_clk or negedge ap_rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!ap_rst_n || clear) begin
            for (int ch = 0; ch < NCH; ch++) streak[d][ch] = 0;
            m_cnt[d] = 0;
            m_fv[d]  = 0;
            m_fid[d] = 0;
         end else begin
            m_nr = 0;
            m_lo = -1;
            for (int ch = 0; ch < NCH; ch++) begin
               if (tvalid[ch] && !tready[ch]) begin
                  streak[d][ch] = streak[d][ch] + 1;
                  if (streak[d][ch] == th[d]) begin
                     m_nr = m_nr + 1;
                     if (m_lo < 0) m_lo = ch;
                  end
               end else begin
                  streak[d][ch] = 0;
               end
            end
            m_cnt[d] = (m_cnt[d] + m_nr > CMAX) ? CMAX : m_cnt[d] + m_nr;
            if (m_fv[d] == 0 && m_nr > 0) begin
               m_fv[d]  = 1;
               m_fid[d] = m_lo;
            end
         end
      end
   end

   task automatic check_dut(input int d, input logic [4:0] b, input logic a, input logic v,
                            input logic [4:0] id, input logic [1:0] c);
      int ef;
      ef = exp_flags(d);
      chk($sformatf("dut%0d flags", d), int'(b), ef);
      chk($sformatf("dut%0d any_block", d), int'(a), (ef != 0) ? 1 : 0);
      chk($sformatf("dut%0d first_blk_vld", d), int'(v), m_fv[d]);
      chk($sformatf("dut%0d first_blk_id", d), int'(id), m_fid[d]);
      chk($sformatf("dut%0d blk_event_cnt", d), int'(c), m_cnt[d]);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge ap_clk) begin
      check_dut(0, blk0, any0, fv0, fid0, cnt0);
      check_dut(1, blk1, any1, fv1, fid1, cnt1);
   end

   // Present one input pattern for n cycles; returns at the falling edge after the last one.
   task automatic cyc(input logic [4:0] v, input logic [4:0] r, input logic c, input int n);
      repeat (n) begin
         tvalid = v;
         tready = r;
         clear  = c;
         @(negedge ap_clk);
      end
      clear = 1'b0;
   endtask

   initial begin
      ap_rst_n = 1'b0;
      clear    = 1'b0;
      tvalid   = 5'($urandom);
      tready   = 5'($urandom);

      // Reset held with random traffic.
      repeat (5) begin
         @(negedge ap_clk);
         tvalid = 5'($urandom);
         tready = 5'($urandom);
      end
      chk("reset flags", int'(blk0), 0);
      chk("reset any", int'(any0), 0);
      chk("reset cnt", int'(cnt0), 0);
      chk("reset first_vld", int'(fv0), 0);

      // Release, then 20 cycles with no stalls.
      ap_rst_n = 1'b1;
      repeat (20) cyc(5'($urandom), 5'h1f, 1'b0, 1);
      chk("idle flags", int'(blk0), 0);
      chk("idle cnt", int'(cnt0), 0);

      // Threshold: ch2 stalls 4 cycles, transfers in cycle 5.
      cyc(5'b00100, 5'b00000, 1'b0, 4);
      chk("thr flags c5", int'(blk0), 5'b00100);
      chk("thr any c5", int'(any0), 1);
      chk("thr cnt c5", int'(cnt0), 1);
      chk("thr fid c5", int'(fid0), 2);
      chk("thr fvld c5", int'(fv0), 1);
      cyc(5'b00100, 5'b00100, 1'b0, 1);
      chk("thr flags c6", int'(blk0), 0);
      chk("thr cnt c6", int'(cnt0), 1);
      chk("thr fid c6", int'(fid0), 2);
      chk("t1 flags after transfer", int'(blk1), 0);

      // Clear returns everything to reset values.
      cyc(5'b00000, 5'b00000, 1'b1, 1);
      chk("clear fvld", int'(fv0), 0);
      chk("clear cnt", int'(cnt0), 0);

      // Broken stall on ch0: 3 stalls, valid low, 3 stalls.
      cyc(5'b00001, 5'b00000, 1'b0, 3);
      cyc(5'b00000, 5'b00000, 1'b0, 1);
      cyc(5'b00001, 5'b00000, 1'b0, 3);
      chk("broken flags", int'(blk0), 0);
      cyc(5'b00000, 5'b00000, 1'b0, 1);
      chk("broken cnt", int'(cnt0), 0);
      chk("broken fvld", int'(fv0), 0);
      chk("t1 broken cnt", int'(cnt1), 2);

      // Simultaneous rise on ch1 and ch3, held 10 cycles.
      cyc(5'b00000, 5'b00000, 1'b1, 1);
      cyc(5'b01010, 5'b00000, 1'b0, 4);
      chk("sim flags c5", int'(blk0), 5'b01010);
      chk("sim cnt c5", int'(cnt0), 2);
      chk("sim fid c5", int'(fid0), 1);
      cyc(5'b01010, 5'b00000, 1'b0, 6);
      chk("sim flags held", int'(blk0), 5'b01010);
      chk("sim cnt held", int'(cnt0), 2);
      cyc(5'b10000, 5'b00000, 1'b0, 4);
      chk("ch4 flags", int'(blk0), 5'b10000);
      chk("ch4 fid", int'(fid0), 1);
      chk("ch4 cnt", int'(cnt0), 3);

      // Saturation: two more events keep the 2-bit counter at 3.
      cyc(5'b00001, 5'b00000, 1'b0, 4);
      cyc(5'b00100, 5'b00000, 1'b0, 4);
      chk("sat flags", int'(blk0), 5'b00100);
      chk("sat cnt", int'(cnt0), 3);
      chk("sat fid", int'(fid0), 1);

      // Clear coincides with ch3's would-be rising edge.
      cyc(5'b01000, 5'b00000, 1'b0, 3);
      cyc(5'b01000, 5'b00000, 1'b1, 1);
      chk("clrpri flags", int'(blk0), 0);
      chk("clrpri any", int'(any0), 0);
      chk("clrpri fvld", int'(fv0), 0);
      chk("clrpri fid", int'(fid0), 0);
      chk("clrpri cnt", int'(cnt0), 0);
      cyc(5'b01000, 5'b00000, 1'b0, 3);
      chk("post-clear 3 stalls", int'(blk0), 0);
      cyc(5'b01000, 5'b00000, 1'b0, 1);
      chk("post-clear 4 stalls", int'(blk0), 5'b01000);
      chk("post-clear fid", int'(fid0), 3);
      chk("post-clear cnt", int'(cnt0), 1);

      // Async reset between edges while ch4 is blocked.
      cyc(5'b10000, 5'b00000, 1'b0, 4);
      chk("pre-arst flags", int'(blk0), 5'b10000);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("arst flags", int'(blk0), 0);
      chk("arst any", int'(any0), 0);
      chk("arst fvld", int'(fv0), 0);
      chk("arst cnt", int'(cnt0), 0);
      chk("arst t1 flags", int'(blk1), 0);
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      cyc(5'b10000, 5'b00000, 1'b0, 3);
      chk("rearm 3 stalls", int'(blk0), 0);
      cyc(5'b10000, 5'b00000, 1'b0, 1);
      chk("rearm 4 stalls", int'(blk0), 5'b10000);
      chk("rearm fid", int'(fid0), 4);
      chk("rearm cnt", int'(cnt0), 1);

      cyc(5'b00000, 5'b00000, 1'b0, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/axis_block_sig_gen.md
# axis_block_sig_gen

Per-channel AXI-Stream stall detector for the hyperspectral dataflow simulation harness. It watches TVALID/TREADY on each dataflow stream and drives the per-channel `axis_block_sigs` vector consumed by the deadlock monitor, asserting a channel's bit once that stream has been stalled for a programmable number of consecutive cycles. It also keeps a sticky record of the first channel to block and a saturating count of block events for end-of-run reporting.

## Interface
- `NUM_CH`, default 5: number of monitored streams, range 1..32.
- `THRESH`, default 16: consecutive stall cycles required before a channel is reported blocked; must be ≥1.
- `CNT_W`, default 16: width of the block-event counter.
- `ap_clk`  in  1  single clock; all state changes on the rising edge.
- `ap_rst_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous clear of all state, equivalent to reset.
- `tvalid`  in  NUM_CH  per-stream TVALID.
- `tready`  in  NUM_CH  per-stream TREADY.
- `axis_block_sigs`  out  NUM_CH  per-stream blocked flag, registered.
- `any_block`  out  1  OR of `axis_block_sigs`, registered in the same cycle as the flags.
- `first_blk_vld`  out  1  sticky; a block has occurred since reset or clear.
- `first_blk_id`  out  5  index of the first channel to block; valid while `first_blk_vld` is high.
- `blk_event_cnt`  out  CNT_W  saturating count of block rising edges.

## Operation
- A stall cycle on channel i is any cycle with `tvalid[i]=1` and `tready[i]=0`.
- Each channel has its own counter `run[i]` and a two-state FSM: IDLE or BLOCKED.
- `run[i]` has width clog2(THRESH+1).
- When a stall cycle occurs and `run[i]<THRESH`, `run[i]` increments.
- `run[i]` saturates at THRESH.
- Any non-stall cycle sets `run[i]` to 0. This covers both a completed transfer (valid and ready high) and valid low.
- IDLE→BLOCKED: on a stall cycle in which `run[i]==THRESH-1` before the edge. This happens on the edge that ends the THRESH-th consecutive stall cycle.
- BLOCKED→IDLE: on any non-stall cycle.
- `axis_block_sigs[i]` is 1 exactly when FSM[i] is BLOCKED.
- Rising edge of channel i = IDLE→BLOCKED transition.
- `blk_event_cnt` adds the number of channels rising on each edge. It saturates at 2^CNT_W−1 and does not wrap.
- `first_blk_id`/`first_blk_vld` are loaded only when `first_blk_vld=0` and at least one channel rises.
  - `first_blk_id` takes the lowest rising index.
  - `first_blk_vld` is then set to 1 and holds until reset or clear.
- Channels are fully independent; a stall on one channel never affects another channel's count.
- `clear=1`: on the next edge all `run`, FSMs and outputs return to reset values. Clear has priority over any concurrent stall or rising event in the same cycle; that event is discarded.

## Timing
- Reset values: `axis_block_sigs=0`, `any_block=0`, `first_blk_vld=0`, `first_blk_id=0`, `blk_event_cnt=0`, all `run=0`, all FSMs IDLE.
- Reset is asynchronous: asserting `ap_rst_n` low mid-operation forces every output to its reset value immediately, without waiting for a clock edge.
- Deassertion of `ap_rst_n` is expected synchronous to `ap_clk` from the harness.
- Assertion latency: stall cycles numbered 1..THRESH.
  - `axis_block_sigs[i]` is high starting in cycle THRESH+1.
  - `any_block`, `blk_event_cnt` and `first_blk_*` update in that same cycle.
- Deassertion latency: with non-stall cycle k, `axis_block_sigs[i]` is low from cycle k+1.
- THRESH=1: a flag is high in the cycle after a single stall cycle.
- A stall broken by one non-stall cycle restarts counting from 0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `ap_rst_n=0` with random `tvalid`/`tready` → all outputs 0. Deassert and drive no stalls for 20 cycles → outputs stay 0.
- Threshold (NUM_CH=5, THRESH=4): ch2 stalls cycles 1–4, transfers in cycle 5.
  - `axis_block_sigs=5'b00100` in cycle 5 only.
  - Cycle 6: all flags 0.
  - `blk_event_cnt=1`, `first_blk_id=2`, `first_blk_vld=1`.
- Broken stall: ch0 stalls 3 cycles, valid low 1 cycle, then stalls 3 cycles → ch0 flag never asserts, `blk_event_cnt=0`.
- Simultaneous rise: ch1 and ch3 start stalling in the same cycle and hold 10 cycles.
  - Both flags rise together in cycle 5.
  - `blk_event_cnt=2`, `first_blk_id=1`.
  - Later, ch4 blocks → `first_blk_id` stays 1, `blk_event_cnt=3`.
- Clear priority and saturation (CNT_W=2): generate 5 block events → `blk_event_cnt` stops at 3. Assert `clear` in the same cycle a channel would rise → next cycle all outputs 0 and `first_blk_vld=0`.
- Async reset mid-block: ch4 BLOCKED, then pull `ap_rst_n` low between edges → flags drop without waiting for an edge. After release, ch4 needs THRESH fresh stall cycles before it re-asserts.
